// File: rtl/item_memory_ctrl.sv
// Burst lookup scheduler for the item memory: round-robin request arbitration,
// per-beat port-A address stepping, and a registered valid/ready hypervector output.
module item_memory_ctrl #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned ImAddrWidth = 32,
  parameter int unsigned NumReq      = 2,
  parameter int unsigned LenWidth    = 8,
  parameter int unsigned IdWidth     = $clog2(NumReq)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0]                    req_cim_i,
  input  logic [NumReq-1:0][ImAddrWidth-1:0]   req_addr_a_i,
  input  logic [NumReq-1:0][ImAddrWidth-1:0]   req_addr_b_i,
  input  logic [NumReq-1:0][LenWidth-1:0]      req_len_i,
  output logic                                 im_port_a_cim_o,
  output logic [ImAddrWidth-1:0]               im_a_addr_o,
  output logic [ImAddrWidth-1:0]               im_b_addr_o,
  input  logic [HVDimension-1:0]               im_a_i,
  input  logic [HVDimension-1:0]               im_b_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [HVDimension-1:0]               out_a_o,
  output logic [HVDimension-1:0]               out_b_o,
  output logic [IdWidth-1:0]                   out_id_o,
  output logic                                 out_last_o,
  output logic                                 busy_o
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [IdWidth-1:0]     rr_q, rr_d;
  logic [LenWidth-1:0]    cnt_q, cnt_d;
  logic [LenWidth-1:0]    len_q, len_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic                   cim_q, cim_d;
  logic [ImAddrWidth-1:0] addr_a_q, addr_a_d;
  logic [ImAddrWidth-1:0] addr_b_q, addr_b_d;
  logic                   out_valid_q, out_valid_d;
  logic [HVDimension-1:0] out_a_q, out_a_d;
  logic [HVDimension-1:0] out_b_q, out_b_d;
  logic [IdWidth-1:0]     out_id_q, out_id_d;
  logic                   out_last_q, out_last_d;

  logic               grant_valid;
  logic [IdWidth-1:0] grant_idx;
  logic               accept;
  logic               capture;
  logic               last_beat;

  // First asserted requester at or above the rr pointer, wrapping around.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < int'(NumReq); k++) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(NumReq)) idx = idx - int'(NumReq);
      if (!grant_valid && req_valid_i[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IdWidth'(idx);
      end
    end
  end

  assign accept = (state_q == StIdle) && grant_valid && !rst_i;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
    assign req_ready_o[gi] = accept && (grant_idx == IdWidth'(gi));
  end

  assign capture   = (state_q == StBurst) && (!out_valid_q || out_ready_i);
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    id_d        = id_q;
    cim_d       = cim_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;

    if (accept) begin
      state_d  = StBurst;
      cim_d    = req_cim_i[grant_idx];
      addr_a_d = req_addr_a_i[grant_idx];
      addr_b_d = req_addr_b_i[grant_idx];
      len_d    = req_len_i[grant_idx];
      id_d     = grant_idx;
      cnt_d    = '0;
      rr_d     = (grant_idx == IdWidth'(NumReq - 1)) ? '0 : grant_idx + IdWidth'(1);
    end

    // Address register doubles as base+counter; on the last beat it holds.
    if (capture) begin
      out_valid_d = 1'b1;
      out_a_d     = im_a_i;
      out_b_d     = im_b_i;
      out_id_d    = id_q;
      out_last_d  = last_beat;
      if (last_beat) begin
        state_d = StIdle;
      end else begin
        cnt_d    = cnt_q + LenWidth'(1);
        addr_a_d = addr_a_q + ImAddrWidth'(1);
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      id_q        <= '0;
      cim_q       <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      id_q        <= id_d;
      cim_q       <= cim_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign im_port_a_cim_o = cim_q;
  assign im_a_addr_o     = addr_a_q;
  assign im_b_addr_o     = addr_b_q;
  assign out_valid_o     = out_valid_q;
  assign out_a_o         = out_a_q;
  assign out_b_o         = out_b_q;
  assign out_id_o        = out_id_q;
  assign out_last_o      = out_last_q;
  assign busy_o          = (state_q == StBurst);

endmodule

// File: tb/tb_item_memory_ctrl.sv
// Bench for item_memory_ctrl: directed scenarios plus random traffic, checked
// each cycle against a burst-level reference model and a beat scoreboard.
module tb_item_memory_ctrl;
  localparam int HV = 512;
  localparam int AW = 32;
  localparam int N  = 2;
  localparam int LW = 8;
  localparam int IW = 1;

  typedef struct {
    logic [HV-1:0] a;
    logic [HV-1:0] b;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_i;
  logic [N-1:0]         req_valid, req_ready, req_cim;
  logic [N-1:0][AW-1:0] req_addr_a, req_addr_b;
  logic [N-1:0][LW-1:0] req_len;
  logic                 im_cim;
  logic [AW-1:0]        im_a_addr, im_b_addr;
  logic [HV-1:0]        im_a, im_b, out_a, out_b;
  logic                 out_valid, out_ready, out_last, busy;
  logic [IW-1:0]        out_id;

  always #5 clk = ~clk;

  function automatic logic [HV-1:0] hv_a(input logic [AW-1:0] addr, input logic cim);
    logic [HV-1:0] r;
    r = '0;
    for (int i = 0; i < HV / 32; i++)
      r[i*32 +: 32] = ((addr + 32'(i)) * 32'h9E37_79B1) ^ (cim ? 32'hC3C3_C3C3 : 32'h0);
    return r;
  endfunction

  function automatic logic [HV-1:0] hv_b(input logic [AW-1:0] addr);
    logic [HV-1:0] r;
    r = '0;
    for (int i = 0; i < HV / 32; i++)
      r[i*32 +: 32] = ~((addr * 32'h85EB_CA6B) + 32'(i * 7));
    return r;
  endfunction

  assign im_a = hv_a(im_a_addr, im_cim);
  assign im_b = hv_b(im_b_addr);

  item_memory_ctrl #(.HVDimension(HV), .ImAddrWidth(AW), .NumReq(N), .LenWidth(LW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cim_i(req_cim),
    .req_addr_a_i(req_addr_a), .req_addr_b_i(req_addr_b), .req_len_i(req_len),
    .im_port_a_cim_o(im_cim), .im_a_addr_o(im_a_addr), .im_b_addr_o(im_b_addr),
    .im_a_i(im_a), .im_b_i(im_b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_a_o(out_a), .out_b_o(out_b), .out_id_o(out_id), .out_last_o(out_last),
    .busy_o(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: burst bookkeeping and the queue of expected beats.
  int            rr_m = 0;
  int            left_m = 0;
  bit            in_burst_m = 0;
  bit            ov_m = 0;
  logic [AW-1:0] cur_addr_m = '0;
  logic [AW-1:0] addrb_m = '0;
  logic          cim_m = 1'b0;
  beat_t         q[$];
  logic [N-1:0]  last_ready = '0;

  task automatic check(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] exp_ready;
    int           g;
    bit           capture;
    exp_ready  = '0;
    g          = -1;
    last_ready = req_ready;
    if (rst_i) begin
      check("ready_in_reset", req_ready, '0);
      q.delete();
      rr_m = 0; left_m = 0; in_burst_m = 0; ov_m = 0;
      cur_addr_m = '0; addrb_m = '0; cim_m = 1'b0;
      return;
    end
    check("busy", busy, in_burst_m);
    check("out_valid", out_valid, ov_m);
    check("im_a_addr", im_a_addr, cur_addr_m);
    check("im_b_addr", im_b_addr, addrb_m);
    check("im_cim", im_cim, cim_m);
    if (ov_m && q.size() != 0) begin
      check("out_a", out_a, q[0].a);
      check("out_b", out_b, q[0].b);
      check("out_id", out_id, q[0].id);
      check("out_last", out_last, q[0].last);
    end
    if (!in_burst_m) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr_m + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("req_ready", req_ready, exp_ready);

    capture = in_burst_m && (!ov_m || out_ready);
    if (ov_m && out_ready && q.size() != 0) void'(q.pop_front());
    if (capture) begin
      left_m--;
      if (left_m == 0) in_burst_m = 0;
      else cur_addr_m = cur_addr_m + 1;
      ov_m = 1;
    end else if (out_ready) begin
      ov_m = 0;
    end
    if (g >= 0) begin
      int len;
      len = int'(req_len[g]);
      for (int j = 0; j <= len; j++) begin
        beat_t bt;
        bt.a    = hv_a(req_addr_a[g] + AW'(j), req_cim[g]);
        bt.b    = hv_b(req_addr_b[g]);
        bt.id   = IW'(g);
        bt.last = (j == len);
        q.push_back(bt);
      end
      in_burst_m = 1;
      left_m     = len + 1;
      cur_addr_m = req_addr_a[g];
      addrb_m    = req_addr_b[g];
      cim_m      = req_cim[g];
      rr_m       = (g + 1) % N;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int g, input logic cim, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [LW-1:0] len);
    int n;
    n = 0;
    req_valid[g] = 1'b1; req_cim[g] = cim;
    req_addr_a[g] = a; req_addr_b[g] = b; req_len[g] = len;
    do begin
      cycle();
      n++;
    end while (!last_ready[g] && n < 1000);
    check("grant_seen", last_ready[g], 1'b1);
    req_valid[g] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    out_ready = 1'b1;
    while ((q.size() != 0 || in_burst_m || ov_m) && n < 3000) begin
      cycle();
      n++;
    end
    cycle();
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    check("drain_idle", busy, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; req_valid = '0; req_cim = '0; req_addr_a = '0; req_addr_b = '0;
    req_len = '0; out_ready = 1'b0;
    cycle(); cycle();
    rst_i = 1'b0;
    cycle();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_a", out_a, '0);
    check("rst_out_b", out_b, '0);
    check("rst_out_id", out_id, '0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_im_a_addr", im_a_addr, '0);
    check("rst_busy", busy, 1'b0);

    // Single burst: 3 beats at addresses 5,6,7 with fixed port-B 9.
    out_ready = 1'b1;
    request(0, 1'b0, 32'd5, 32'd9, 8'd2);
    check("single_ready_onehot", last_ready, 2'b01);
    check("single_first_addr", im_a_addr, 32'd5);
    cycle();
    check("single_second_addr", im_a_addr, 32'd6);
    drain();

    // Both requesters always valid with len=0: grants alternate.
    req_cim = '0; req_addr_a[0] = 32'h100; req_addr_a[1] = 32'h200;
    req_addr_b[0] = 32'h11; req_addr_b[1] = 32'h22; req_len = '0;
    req_valid = 2'b11;
    for (int i = 0; i < 12; i++) cycle();
    drain();

    // Backpressure: stall 4 cycles after the first beat.
    request(0, 1'b0, 32'd100, 32'd55, 8'd3);
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("stall_addr_held", im_a_addr, 32'd101);
    check("stall_last_low", out_last, 1'b0);
    out_ready = 1'b1;
    drain();

    // Port-A address wrap at the top of the address space.
    request(0, 1'b0, 32'hFFFF_FFFE, 32'd3, 8'd3);
    drain();

    // Maximum-length CiM burst from requester 1.
    request(1, 1'b1, 32'd0, 32'd7, 8'd255);
    cycle();
    check("cim_mode", im_cim, 1'b1);
    drain();
    check("cim_last_addr", im_a_addr, 32'd255);

    // Reset in the middle of a len=7 burst.
    request(0, 1'b0, 32'h40, 32'd1, 8'd7);
    cycle(); cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    cycle();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_addr", im_a_addr, '0);
    req_valid[1] = 1'b1; req_addr_a[1] = 32'h300; req_addr_b[1] = 32'h33; req_len[1] = 8'd1;
    request(0, 1'b0, 32'h80, 32'd2, 8'd2);
    check("midrst_rr_zero", last_ready, 2'b01);
    drain();

    // Random traffic with random downstream backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom_range(0, 3));
      for (int g = 0; g < N; g++) begin
        req_cim[g]    = 1'($urandom_range(0, 1));
        req_addr_a[g] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                    : 32'($urandom);
        req_addr_b[g] = 32'($urandom);
        req_len[g]    = LW'($urandom_range(0, 4));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
